beam_combiner_ctrl: RTL and testbench

Sequencing and configuration controller for the four-channel weighted beam combiner datapath. It aligns the four input stream handshakes so that all enabled channels are accepted in lockstep. It gates datapath capture against output-FIFO credits and tracks frame boundaries. It holds double-buffered beam weights that swap atomically only between frames.

---
 rtl/beam_combiner_ctrl.sv | 157 +++++++++++++++
 tb/tb_beam_combiner_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_combiner_ctrl.sv
// Four-channel beam combiner sequencer: lockstep input alignment,
// output-FIFO credit gating, frame tracking and double-buffered weights.
module beam_combiner_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int CREDITS         = 8,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    ch_enable,
  input  logic [NUM_CH-1:0]                    s_tvalid,
  input  logic [NUM_CH-1:0]                    s_tlast,
  output logic [NUM_CH-1:0]                    s_tready,
  output logic                                 dp_fire,
  output logic                                 dp_last,
  input  logic                                 fifo_pop,
  input  logic                                 cfg_wr,
  input  logic [$clog2(2*NUM_CH)-1:0]          cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]              cfg_data,
  input  logic                                 cfg_commit,
  output logic [2*NUM_CH*WEIGHT_WIDTH-1:0]     weights_active,
  output logic                                 commit_pending,
  output logic [NUM_CH-1:0]                    active_mask,
  output logic [$clog2(CREDITS+1)-1:0]         credits,
  output logic [FRAME_CNT_WIDTH-1:0]           frame_count,
  output logic                                 err_last_misalign,
  input  logic                                 err_clear,
  output logic [1:0]                           state
);

  localparam int AW = $clog2(2*NUM_CH);
  localparam int CW = $clog2(CREDITS+1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] SWAP   = 2'd2;

  localparam logic [AW:0]   NUM_W    = (AW+1)'(2*NUM_CH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [NUM_CH-1:0] valid_act;
  logic [NUM_CH-1:0] last_act;
  logic              fire;
  logic              last_any;
  logic              last_all;
  logic              misalign;
  logic              boundary;
  logic              in_frame;

  logic [2*NUM_CH-1:0][WEIGHT_WIDTH-1:0] shadow_w;
  logic [2*NUM_CH-1:0][WEIGHT_WIDTH-1:0] active_w;

  assign valid_act = s_tvalid & active_mask;
  assign last_act  = s_tlast & active_mask;

  assign fire = (state == STREAM)
             && (active_mask != '0)
             && (valid_act == active_mask)
             && (credits != '0);

  assign last_any = |last_act;
  assign last_all = (last_act == active_mask);
  assign misalign = last_any && !last_all;

  assign s_tready = active_mask & {NUM_CH{fire}};
  assign dp_fire  = fire;
  assign dp_last  = fire && last_any;

  // A boundary is either the closing beat or an idle gap between frames
  assign boundary = dp_last || (!in_frame && !fire);

  assign weights_active = active_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      credits           <= CRED_MAX;
      frame_count       <= '0;
      in_frame          <= 1'b0;
      err_last_misalign <= 1'b0;
      shadow_w          <= '0;
    end else begin
      if (fire && !fifo_pop) begin
        credits <= credits - CW'(1);
      end else if (fifo_pop && !fire && (credits < CRED_MAX)) begin
        credits <= credits + CW'(1);
      end

      if (dp_last) begin
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      end

      if (fire) begin
        in_frame <= !last_any;
      end

      if (fire && misalign) begin
        err_last_misalign <= 1'b1;
      end else if (err_clear) begin
        err_last_misalign <= 1'b0;
      end

      if (cfg_wr && ({1'b0, cfg_addr} < NUM_W)) begin
        shadow_w[cfg_addr] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      active_mask    <= '0;
      active_w       <= '0;
      commit_pending <= 1'b0;
    end else begin
      // The swap cycle consumes the pending request; a new one re-arms it
      if (state == SWAP) begin
        commit_pending <= cfg_commit;
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (commit_pending) begin
            state <= SWAP;
          end else if (ch_enable != '0) begin
            active_mask <= ch_enable;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (boundary) begin
            if (commit_pending) begin
              state <= SWAP;
            end else if (ch_enable == '0) begin
              state <= IDLE;
            end else begin
              active_mask <= ch_enable;
            end
          end
        end
        SWAP: begin
          active_w <= shadow_w;
          if (ch_enable != '0) begin
            active_mask <= ch_enable;
            state       <= STREAM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_combiner_ctrl.sv
// Directed plus randomized bench for beam_combiner_ctrl with a
// counting-based reference model of the sequencing rules.
module tb_beam_combiner_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  ch_enable;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic        dp_fire;
  logic        dp_last;
  logic        fifo_pop;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic [63:0] weights_active;
  logic        commit_pending;
  logic [3:0]  active_mask;
  logic [3:0]  credits;
  logic [15:0] frame_count;
  logic        err_last_misalign;
  logic        err_clear;
  logic [1:0]  state;

  beam_combiner_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .ch_enable         (ch_enable),
    .s_tvalid          (s_tvalid),
    .s_tlast           (s_tlast),
    .s_tready          (s_tready),
    .dp_fire           (dp_fire),
    .dp_last           (dp_last),
    .fifo_pop          (fifo_pop),
    .cfg_wr            (cfg_wr),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_commit        (cfg_commit),
    .weights_active    (weights_active),
    .commit_pending    (commit_pending),
    .active_mask       (active_mask),
    .credits           (credits),
    .frame_count       (frame_count),
    .err_last_misalign (err_last_misalign),
    .err_clear         (err_clear),
    .state             (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 streaming, 2 weight swap
  int         m_phase;
  logic [3:0] m_mask;
  int         m_cred;
  int         m_frames;
  bit         m_err;
  bit         m_pend;
  bit         m_inframe;
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  bit         m_fire;
  bit         m_last;
  bit         m_mis;

  logic       obs_fire;
  logic       obs_last;
  logic [3:0] obs_ready;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_mask    = 4'h0;
    m_cred    = 8;
    m_frames  = 0;
    m_err     = 1'b0;
    m_pend    = 1'b0;
    m_inframe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = 8'h00;
      m_active[k] = 8'h00;
    end
  endtask

  task automatic model_comb();
    int nact = 0;
    int nvalid = 0;
    int nlast = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_mask[i]) begin
        nact++;
        if (s_tvalid[i]) nvalid++;
        if (s_tlast[i]) nlast++;
      end
    end
    m_fire = (m_phase == 1) && (nact > 0) && (nvalid == nact) && (m_cred > 0);
    m_last = m_fire && (nlast > 0);
    m_mis  = m_fire && (nlast > 0) && (nlast < nact);
  endtask

  task automatic model_edge();
    bit bnd;
    bit pend_old;
    if (reset) begin
      model_reset();
      return;
    end
    bnd = m_last || (!m_inframe && !m_fire);
    pend_old = m_pend;
    if (m_mis) m_err = 1'b1;
    else if (err_clear) m_err = 1'b0;
    if (m_fire && !fifo_pop) m_cred--;
    else if (fifo_pop && !m_fire && m_cred < 8) m_cred++;
    if (m_last) m_frames = (m_frames + 1) % 65536;
    if (m_fire) m_inframe = !m_last;
    if (m_phase == 2) m_pend = cfg_commit;
    else if (cfg_commit) m_pend = 1'b1;
    case (m_phase)
      0: begin
        if (pend_old) m_phase = 2;
        else if (ch_enable != 0) begin
          m_mask = ch_enable;
          m_phase = 1;
        end
      end
      1: begin
        if (bnd) begin
          if (pend_old) m_phase = 2;
          else if (ch_enable == 0) m_phase = 0;
          else m_mask = ch_enable;
        end
      end
      default: begin
        for (int k = 0; k < 8; k++) m_active[k] = m_shadow[k];
        if (ch_enable != 0) begin
          m_mask = ch_enable;
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    endcase
    if (cfg_wr) m_shadow[cfg_addr] = cfg_data;
  endtask

  function automatic logic [63:0] exp_weights();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = m_active[k];
    return w;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // on the falling edge, then the model advances on the rising edge.
  task automatic step();
    logic [3:0] rdy;
    #4;
    model_comb();
    rdy = m_fire ? m_mask : 4'h0;
    chk("dp_fire", 64'(dp_fire), 64'(m_fire));
    chk("dp_last", 64'(dp_last), 64'(m_last));
    chk("s_tready", 64'(s_tready), 64'(rdy));
    chk("state", 64'(state), 64'(m_phase));
    chk("active_mask", 64'(active_mask), 64'(m_mask));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("frame_count", 64'(frame_count), 64'(m_frames));
    chk("err", 64'(err_last_misalign), 64'(m_err));
    chk("pending", 64'(commit_pending), 64'(m_pend));
    chk("weights", weights_active, exp_weights());
    obs_fire  = dp_fire;
    obs_last  = dp_last;
    obs_ready = s_tready;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    int nf;
    reset      = 1'b1;
    ch_enable  = 4'h0;
    s_tvalid   = 4'h0;
    s_tlast    = 4'h0;
    fifo_pop   = 1'b0;
    cfg_wr     = 1'b0;
    cfg_addr   = 3'd0;
    cfg_data   = 8'h00;
    cfg_commit = 1'b0;
    err_clear  = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    step();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_credits", 64'(credits), 64'd8);
    chk("rst_mask", 64'(active_mask), 64'd0);
    chk("rst_weights", weights_active, 64'd0);
    reset = 1'b0;

    // One four-beat frame on all channels
    ch_enable = 4'hF;
    s_tvalid  = 4'hF;
    step();
    nf = 0;
    for (int b = 0; b < 4; b++) begin
      s_tlast = (b == 3) ? 4'hF : 4'h0;
      step();
      nf += int'(obs_fire);
    end
    chk("t1_fires", 64'(nf), 64'd4);
    chk("t1_last", 64'(obs_last), 64'd1);
    chk("t1_frames", 64'(frame_count), 64'd1);
    chk("t1_credits", 64'(credits), 64'd4);

    // Credit exhaustion
    s_tvalid = 4'h0;
    s_tlast  = 4'h0;
    fifo_pop = 1'b1;
    repeat (4) step();
    fifo_pop = 1'b0;
    s_tvalid = 4'hF;
    nf = 0;
    repeat (10) begin
      step();
      nf += int'(obs_fire);
    end
    chk("t2_fires", 64'(nf), 64'd8);
    chk("t2_stall_fire", 64'(obs_fire), 64'd0);
    chk("t2_stall_ready", 64'(obs_ready), 64'd0);
    fifo_pop = 1'b1;
    s_tvalid = 4'h0;
    step();
    fifo_pop = 1'b0;
    s_tvalid = 4'hF;
    step();
    chk("t2_pop_fire", 64'(obs_fire), 64'd1);
    chk("t2_cred0", 64'(credits), 64'd0);
    fifo_pop = 1'b1;
    s_tvalid = 4'h0;
    repeat (8) step();
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    step();
    s_tlast  = 4'h0;

    // Partial valid blocks everything
    s_tvalid = 4'b1101;
    step();
    chk("t3_nofire", 64'(obs_fire), 64'd0);
    chk("t3_noready", 64'(obs_ready), 64'd0);
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    step();
    chk("t3_fire", 64'(obs_fire), 64'd1);
    s_tlast  = 4'h0;

    // Mid-frame weight write and commit
    cfg_wr     = 1'b1;
    cfg_addr   = 3'd3;
    cfg_data   = 8'h40;
    cfg_commit = 1'b1;
    step();
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    step();
    chk("t4_hold_w", weights_active, 64'd0);
    chk("t4_pend", 64'(commit_pending), 64'd1);
    s_tlast = 4'hF;
    step();
    chk("t4_last_w", weights_active, 64'd0);
    chk("t4_swap_state", 64'(state), 64'd2);
    s_tlast = 4'h0;
    step();
    chk("t4_swap_nofire", 64'(obs_fire), 64'd0);
    chk("t4_w3", 64'(weights_active[31:24]), 64'h40);
    chk("t4_pend_clr", 64'(commit_pending), 64'd0);
    chk("t4_stream", 64'(state), 64'd1);

    // Misaligned tlast
    s_tlast = 4'b0011;
    step();
    chk("t5_last", 64'(obs_last), 64'd1);
    chk("t5_err", 64'(err_last_misalign), 64'd1);
    err_clear = 1'b1;
    step();
    chk("t5_err_wins", 64'(err_last_misalign), 64'd1);
    s_tlast  = 4'h0;
    s_tvalid = 4'h0;
    step();
    chk("t5_err_clr", 64'(err_last_misalign), 64'd0);
    err_clear = 1'b0;

    // Enable change deferred to frame boundary
    s_tvalid = 4'hF;
    step();
    ch_enable = 4'b0001;
    step();
    chk("t6_mask_hold", 64'(active_mask), 64'hF);
    s_tlast = 4'hF;
    step();
    chk("t6_mask_new", 64'(active_mask), 64'h1);
    s_tlast = 4'h0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        ch_enable = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      s_tvalid   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 3) == 0)
        s_tlast = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      else
        s_tlast = 4'h0;
      fifo_pop   = 1'($urandom);
      cfg_wr     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 3'($urandom);
      cfg_data   = 8'($urandom);
      cfg_commit = ($urandom_range(0, 9) == 0);
      err_clear  = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
